// File: rtl/counter_pkg.sv
// Shared types and default step constants for the port reader / accumulator.
//   rd_state_t  : FSM state encoding of port_reader_acc
//   A_STEP_D    : default step at which port A loads W
//   B_STEP_D    : default step at which port B is added to W
//   LAST_STEP_D : default final step of a sequence
package counter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT_A,
    WAIT_B,
    DONE
  } rd_state_t;

  localparam int unsigned A_STEP_D    = 10;
  localparam int unsigned B_STEP_D    = 20;
  localparam int unsigned LAST_STEP_D = 30;

endpackage

// File: rtl/step_counter.sv
// Step counter for the port reader sequence.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears q
//   clr : synchronous clear to zero, has priority over en
//   en  : increment by one, wraps modulo 2**WIDTH
//   q   : current count
module step_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/port_reader_acc.sv
// Counter-driven accumulator that reads two input ports over valid/ready.
// A step counter sequences W: in RUN, W accumulates the step value each
// cycle; at A_STEP W is loaded from port A, at B_STEP port B is added to W,
// and at LAST_STEP the final addition is made and a one-cycle done is issued.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : begin a sequence (sampled only in IDLE)
//   in_a       : port A data,  in_a_valid / in_a_ready handshake
//   in_b       : port B data,  in_b_valid / in_b_ready handshake
//   w          : accumulator value
//   step       : current step count
//   busy       : high while the sequence runs or waits on a port
//   done       : one-cycle pulse when the sequence completes
//   ovf        : sticky carry-out of any W addition in the current sequence
module port_reader_acc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned A_STEP    = A_STEP_D,
  parameter int unsigned B_STEP    = B_STEP_D,
  parameter int unsigned LAST_STEP = LAST_STEP_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_a_valid,
  output logic             in_a_ready,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_b_valid,
  output logic             in_b_ready,
  output logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] step,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  // Step ordering must hold and LAST_STEP must be representable in step.
  if (!((A_STEP < B_STEP) && (B_STEP < LAST_STEP) &&
        (64'(LAST_STEP) < (64'd1 << WIDTH)))) begin : g_bad_steps
    $error("port_reader_acc: need A_STEP < B_STEP < LAST_STEP < 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] A_STEP_W    = A_STEP[WIDTH-1:0];
  localparam logic [WIDTH-1:0] B_STEP_W    = B_STEP[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LAST_STEP_W = LAST_STEP[WIDTH-1:0];

  rd_state_t        state;
  logic             at_a;
  logic             at_b;
  logic             at_last;
  logic             step_clr;
  logic             step_en;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  assign at_a    = (step == A_STEP_W);
  assign at_b    = (step == B_STEP_W);
  assign at_last = (step == LAST_STEP_W);

  // The counter only advances on plain RUN steps and on a completed port
  // read; during a wait it sits at X_STEP, so one increment yields X_STEP+1.
  assign step_clr = (state == IDLE) && start;
  assign step_en  = ((state == RUN) && !at_a && !at_b && !at_last) ||
                    ((state == WAIT_A) && in_a_valid) ||
                    ((state == WAIT_B) && in_b_valid);

  step_counter #(
    .WIDTH (WIDTH)
  ) u_step (
    .clk (clk),
    .rst (rst),
    .clr (step_clr),
    .en  (step_en),
    .q   (step)
  );

  // One shared adder: W + step in RUN, W + in_b in WAIT_B. The extra top bit
  // is the carry-out feeding the sticky overflow flag.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    addend = step;
    if (state == WAIT_B) begin
      addend = in_b;
    end
  end

  assign sum = {1'b0, w} + {1'b0, addend};

  // FSM with registered outputs. Ready is only ever high in its own wait
  // state, so valid alone qualifies the transfer inside that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      w          <= '0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_a_ready <= 1'b0;
      in_b_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            w     <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (at_a) begin
            state      <= WAIT_A;
            in_a_ready <= 1'b1;
          end else if (at_b) begin
            state      <= WAIT_B;
            in_b_ready <= 1'b1;
          end else begin
            w   <= sum[WIDTH-1:0];
            ovf <= ovf | sum[WIDTH];
            if (at_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        WAIT_A: begin
          if (in_a_valid) begin
            w          <= in_a;
            in_a_ready <= 1'b0;
            state      <= RUN;
          end
        end
        WAIT_B: begin
          if (in_b_valid) begin
            w          <= sum[WIDTH-1:0];
            ovf        <= ovf | sum[WIDTH];
            in_b_ready <= 1'b0;
            state      <= RUN;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
